// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared FSM state enum and default sizes for sram_port_arbiter
package sram_arb_pkg;
  typedef enum logic {INIT, ACTIVE} state_t;
  localparam int BITS = 64;
  localparam int WORD_DEPTH = 128;
  localparam int ADD_WIDTH = 7;
endpackage

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2: 2-way round-robin grant (ports clk, rst, en, req_w, req_r -> gnt_w, gnt_r); last_w pointer favours write after reset and moves only on a grant
module sram_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_w,
  input  logic req_r,
  output logic gnt_w,
  output logic gnt_r
);
  logic last_w_q, last_w_d;
  always_comb begin
    gnt_w = en && req_w && (!req_r || !last_w_q);
    gnt_r = en && req_r && (!req_w || last_w_q);
    last_w_d = gnt_w ? 1'b1 : gnt_r ? 1'b0 : last_w_q;
  end
  always_ff @(posedge clk) last_w_q <= rst ? 1'b0 : last_w_d;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: write/read port arbiter for one 1-cycle-latency single-port SRAM (clock, reset, w_*/r_* requests, resp_*, init_done, sram_CEB/WEB/A/D/Q); SRAM_ARB_INIT_EN adds a zero-fill sweep after reset
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int Bits       = BITS,
  parameter int Word_Depth = WORD_DEPTH,
  parameter int Add_Width  = ADD_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [Add_Width-1:0] w_addr,
  input  logic [Bits-1:0]      w_data,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [Add_Width-1:0] r_addr,
  output logic                 resp_valid,
  output logic [Bits-1:0]      resp_data,
  output logic                 init_done,
  output logic                 sram_CEB,
  output logic                 sram_WEB,
  output logic [Add_Width-1:0] sram_A,
  output logic [Bits-1:0]      sram_D,
  input  logic [Bits-1:0]      sram_Q
);
  logic active, init_wr, gnt_w, gnt_r, resp_valid_q, resp_valid_d;
  logic [Add_Width-1:0] sweep_a;
  logic [Bits-1:0] hold_q, hold_d;
`ifdef SRAM_ARB_INIT_EN
  state_t state_q, state_d;
  logic [Add_Width-1:0] init_cnt_q, init_cnt_d;
  always_comb begin
    init_wr = !reset && state_q == INIT;
    active = !reset && state_q == ACTIVE;
    sweep_a = init_cnt_q;
    init_cnt_d = init_wr ? init_cnt_q + 1'b1 : init_cnt_q;
    state_d = init_wr && init_cnt_q == Add_Width'(Word_Depth - 1) ? ACTIVE : state_q;
  end
  always_ff @(posedge clock) begin
    state_q <= reset ? INIT : state_d;
    init_cnt_q <= reset ? '0 : init_cnt_d;
  end
`else
  assign init_wr = 1'b0;
  assign active = !reset;
  assign sweep_a = '0;
`endif
  assign init_done = active;
  sram_rr_arb2 u_arb (
    .clk  (clock),
    .rst  (reset),
    .en   (active),
    .req_w(w_valid),
    .req_r(r_valid),
    .gnt_w(gnt_w),
    .gnt_r(gnt_r)
  );
  always_comb begin
    w_ready = gnt_w;
    r_ready = gnt_r;
    sram_CEB = !(init_wr || gnt_w || gnt_r);
    sram_WEB = !(init_wr || gnt_w);
    sram_A = init_wr ? sweep_a : gnt_w ? w_addr : gnt_r ? r_addr : '0;
    sram_D = gnt_w ? w_data : '0;
    resp_valid_d = gnt_r;
    hold_d = resp_valid_q ? sram_Q : hold_q;
    resp_valid = resp_valid_q && !reset;
    resp_data = reset ? '0 : resp_valid_q ? sram_Q : hold_q;
  end
  always_ff @(posedge clock) begin
    resp_valid_q <= reset ? 1'b0 : resp_valid_d;
    hold_q <= reset ? '0 : hold_d;
  end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter Bits, default 64, data width.
REQ-002 SHALL have parameter Word_Depth, default 128, number of SRAM entries.
REQ-003 SHALL have parameter Add_Width, default 7, address width (log2 Word_Depth).
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port w_valid  input  1  write request.
REQ-007 SHALL have port w_ready  output  1  write accepted this cycle.
REQ-008 SHALL have port w_addr  input  Add_Width  write address.
REQ-009 SHALL have port w_data  input  Bits  write data.
REQ-010 SHALL have port r_valid  input  1  read request.
REQ-011 SHALL have port r_ready  output  1  read accepted this cycle.
REQ-012 SHALL have port r_addr  input  Add_Width  read address.
REQ-013 SHALL have port resp_valid  output  1  read data valid (no backpressure).
REQ-014 SHALL have port resp_data  output  Bits  read data.
REQ-015 SHALL have port init_done  output  1  high once the arbiter accepts requests.
REQ-016 SHALL have ports sram_CEB, sram_WEB (output, 1, active-low), sram_A (output, Add_Width), sram_D (output, Bits), sram_Q (input, Bits); these connect to one single-port SRAM macro with 1-cycle read latency.

Function
REQ-017 SHALL implement FSM states INIT and ACTIVE; INIT -> ACTIVE when the init counter reaches Word_Depth-1 and that write issues; ACTIVE is terminal until reset.
REQ-018 In INIT, SHALL write zero to address init_cnt each cycle (CEB=0, WEB=0, D=0), with init_cnt counting 0..Word_Depth-1; w_ready=r_ready=0 and init_done=0.
REQ-019 In ACTIVE, SHALL assert init_done=1 and grant at most one request per cycle.
REQ-020 With only one of w_valid/r_valid high, SHALL grant it in the same cycle (ready combinational from valid and state).
REQ-021 With both high, SHALL grant the requester not granted most recently (round-robin pointer last_w); after reset the pointer favours the write requester.
REQ-022 The pointer SHALL update only on a grant.
REQ-023 A write grant SHALL drive CEB=0, WEB=0, A=w_addr, D=w_data in the same cycle.
REQ-024 A read grant SHALL drive CEB=0, WEB=1, A=r_addr.
REQ-025 With no grant, SHALL drive CEB=1, WEB=1, and A=0, D=0.
REQ-026 A read granted in cycle N SHALL produce resp_valid=1 in cycle N+1 only, with resp_data=sram_Q.
REQ-027 resp_data SHALL hold the last returned value in all cycles after resp_valid (hold register); the macro's non-read Q SHALL never reach resp_data.
REQ-028 A write and a read to the same address granted in consecutive cycles SHALL return the newly written data (ordering via the macro; no forwarding).
REQ-029 Back-to-back reads SHALL sustain one response per cycle.

Reset
REQ-030 Reset SHALL set: state=INIT (ACTIVE if the init feature is compiled out), init_cnt=0, last_w=0, resp_valid=0, hold register=0, init_done=0.
REQ-031 During reset, SHALL drive CEB=1, WEB=1, w_ready=0, r_ready=0.
REQ-032 Reset asserted mid-INIT SHALL restart the sweep at address 0.
REQ-033 Reset asserted the cycle after a read grant SHALL suppress that response (resp_valid=0).

Configuration
REQ-034 Macro SRAM_ARB_INIT_EN SHALL control the init sweep.
REQ-035 With SRAM_ARB_INIT_EN defined, the INIT sweep SHALL occur: Word_Depth cycles after reset deassertion.
REQ-036 With SRAM_ARB_INIT_EN undefined, the INIT state and init_cnt SHALL be absent, and init_done=1 in the first cycle after reset.

Structure
REQ-037 Package sram_arb_pkg SHALL hold the state enum (INIT, ACTIVE) and the default Bits/Word_Depth/Add_Width constants.
REQ-038 A sub-module sram_rr_arb2 (2-way round-robin grant with pointer) is natural and SHALL be used.
REQ-039 The SRAM macro SHALL be instantiated outside this block.

Verification
REQ-040 Reset with SRAM_ARB_INIT_EN set -> 128 consecutive writes of 0 to A=0..127, then init_done=1; w_ready stays 0 throughout.
REQ-041 Write addr 5 data 0xDEAD_BEEF_0123_4567, then read addr 5 -> resp_valid one cycle after r_ready, resp_data=0xDEADBEEF01234567.
REQ-042 w_valid and r_valid held high for 4 cycles -> grants alternate W,R,W,R.
REQ-043 Read addr 9 (never written, post-init) then idle 3 cycles -> resp_data=0 and stable for all 3 idle cycles.
REQ-044 Reset at sweep cycle 60 -> next write goes to A=0; the sweep completes after 128 further cycles.
REQ-045 Reset the cycle after a read grant -> resp_valid=0 and resp_data=0.
